// File: rtl/trace_issue_queue.sv
`default_nettype none
// ============================================================================
// Module  : trace_issue_queue
// Brief   : In-order trace record FIFO; forwards cache accesses, converts
//           stats-control opcodes into single-cycle pulses, drops illegal ops.
// Revision: 1.0 - initial release
// ============================================================================
module trace_issue_queue #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [3:0]                 in_op_i,
    input  logic [ADDR_W-1:0]          in_addr_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [1:0]                 Access_type_o,
    output logic [ADDR_W-1:0]          Hex_address_o,
    output logic                       clear_stats_o,
    output logic                       dump_stats_o,
    output logic [$clog2(DEPTH+1)-1:0] occupancy_o,
    output logic [31:0]                issued_count_o,
    output logic [15:0]                dropped_count_o,
    output logic                       idle_o
);

    localparam int         c_ptr_w    = $clog2(DEPTH);
    localparam int         c_cnt_w    = $clog2(DEPTH + 1);
    localparam int         c_ent_w    = 4 + ADDR_W;
    localparam logic [3:0] c_op_clear = 4'd8;
    localparam logic [3:0] c_op_dump  = 4'd9;

    typedef enum logic [0:0] {
        S_RUN   = 1'b0,
        S_PULSE = 1'b1
    } state_t;

    logic [c_ent_w-1:0] r_mem_q [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr_q, r_wr_ptr_d;
    logic [c_ptr_w-1:0] r_rd_ptr_q, r_rd_ptr_d;
    logic [c_cnt_w-1:0] r_count_q, r_count_d;
    logic [31:0]        r_issued_q, r_issued_d;
    logic [15:0]        r_dropped_q, r_dropped_d;
    state_t             r_state_q, r_state_d;
    logic               r_pulse_dump_q, r_pulse_dump_d;

    logic               w_full;
    logic               w_empty;
    logic [c_ent_w-1:0] w_head;
    logic [3:0]         w_head_op;
    logic               w_is_access;
    logic               w_is_ctrl;
    logic               w_push;
    logic               w_pop;

    assign w_full      = (r_count_q == c_cnt_w'(DEPTH));
    assign w_empty     = (r_count_q == '0);
    assign w_head      = r_mem_q[r_rd_ptr_q];
    assign w_head_op   = w_head[c_ent_w-1:ADDR_W];
    assign w_is_access = (w_head_op[3:2] == 2'b00) && (w_head_op[1:0] != 2'b11);
    assign w_is_ctrl   = (w_head_op == c_op_clear) || (w_head_op == c_op_dump);

    assign w_push = in_valid_i && !w_full;
    // Control and illegal entries never wait on the cache; only accesses stall.
    assign w_pop  = !w_empty && (!w_is_access || out_ready_i);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_q[r_wr_ptr_q] <= {in_op_i, in_addr_i};
        end
    end

    always_comb begin
        r_wr_ptr_d     = r_wr_ptr_q;
        r_rd_ptr_d     = r_rd_ptr_q;
        r_count_d      = r_count_q;
        r_issued_d     = r_issued_q;
        r_dropped_d    = r_dropped_q;
        r_state_d      = S_RUN;
        r_pulse_dump_d = r_pulse_dump_q;

        if (w_push) begin
            r_wr_ptr_d = r_wr_ptr_q + c_ptr_w'(1);
        end
        if (w_pop) begin
            r_rd_ptr_d = r_rd_ptr_q + c_ptr_w'(1);
        end
        if (w_push && !w_pop) begin
            r_count_d = r_count_q + c_cnt_w'(1);
        end else if (!w_push && w_pop) begin
            r_count_d = r_count_q - c_cnt_w'(1);
        end

        if (w_pop && w_is_access) begin
            r_issued_d = r_issued_q + 32'd1;
        end
        if (w_pop && !w_is_access && !w_is_ctrl && (r_dropped_q != 16'hFFFF)) begin
            r_dropped_d = r_dropped_q + 16'd1;
        end

        // PULSE is re-entered on every CTRL pop so consecutive controls pulse back to back.
        if (w_pop && w_is_ctrl) begin
            r_state_d      = S_PULSE;
            r_pulse_dump_d = (w_head_op == c_op_dump);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr_q     <= '0;
            r_rd_ptr_q     <= '0;
            r_count_q      <= '0;
            r_issued_q     <= '0;
            r_dropped_q    <= '0;
            r_state_q      <= S_RUN;
            r_pulse_dump_q <= 1'b0;
        end else begin
            r_wr_ptr_q     <= r_wr_ptr_d;
            r_rd_ptr_q     <= r_rd_ptr_d;
            r_count_q      <= r_count_d;
            r_issued_q     <= r_issued_d;
            r_dropped_q    <= r_dropped_d;
            r_state_q      <= r_state_d;
            r_pulse_dump_q <= r_pulse_dump_d;
        end
    end

    assign in_ready_o      = !w_full;
    assign out_valid_o     = !w_empty && w_is_access;
    assign Access_type_o   = w_head_op[1:0];
    assign Hex_address_o   = w_head[ADDR_W-1:0];
    assign clear_stats_o   = (r_state_q == S_PULSE) && !r_pulse_dump_q;
    assign dump_stats_o    = (r_state_q == S_PULSE) && r_pulse_dump_q;
    assign occupancy_o     = r_count_q;
    assign issued_count_o  = r_issued_q;
    assign dropped_count_o = r_dropped_q;
    assign idle_o          = w_empty && (r_state_q == S_RUN);

endmodule
`default_nettype wire

// File: tb/tb_trace_issue_queue.sv
`default_nettype none
// ============================================================================
// Module  : tb_trace_issue_queue
// Brief   : Directed vector table plus scoreboarded streams for trace_issue_queue.
// Revision: 1.0 - initial release
// ============================================================================
module tb_trace_issue_queue;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [31:0] in_addr;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  access_type;
    logic [31:0] hex_address;
    logic        clear_stats;
    logic        dump_stats;
    logic [3:0]  occupancy;
    logic [31:0] issued_count;
    logic [15:0] dropped_count;
    logic        idle;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    trace_issue_queue #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid_i      (in_valid),
        .in_ready_o      (in_ready),
        .in_op_i         (in_op),
        .in_addr_i       (in_addr),
        .out_valid_o     (out_valid),
        .out_ready_i     (out_ready),
        .Access_type_o   (access_type),
        .Hex_address_o   (hex_address),
        .clear_stats_o   (clear_stats),
        .dump_stats_o    (dump_stats),
        .occupancy_o     (occupancy),
        .issued_count_o  (issued_count),
        .dropped_count_o (dropped_count),
        .idle_o          (idle)
    );

    typedef struct {
        logic        iv;
        logic [3:0]  op;
        logic [31:0] addr;
        logic        ordy;
        logic        ov;
        logic [1:0]  ty;
        logic [31:0] ha;
        logic        clr;
        logic        dmp;
        logic        idl;
        logic [3:0]  occ;
        logic [31:0] iss;
        logic [15:0] drp;
    } vec_t;

    vec_t vt[21];

    function automatic vec_t mk(input logic iv, input logic [3:0] op, input logic [31:0] addr,
                                input logic ordy, input logic ov, input logic [1:0] ty,
                                input logic [31:0] ha, input logic clr, input logic dmp,
                                input logic idl, input logic [3:0] occ, input logic [31:0] iss,
                                input logic [15:0] drp);
        vec_t v;
        v.iv = iv; v.op = op; v.addr = addr; v.ordy = ordy;
        v.ov = ov; v.ty = ty; v.ha = ha; v.clr = clr; v.dmp = dmp;
        v.idl = idl; v.occ = occ; v.iss = iss; v.drp = drp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_state(input string name);
        chk(name, 64'({in_ready, out_valid, clear_stats, dump_stats, idle, occupancy,
                       issued_count, dropped_count}),
            64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 32'd0, 16'd0}));
    endtask

    task automatic drive(input logic iv, input logic [3:0] op, input logic [31:0] addr,
                         input logic ordy);
        in_valid  = iv;
        in_op     = op;
        in_addr   = addr;
        out_ready = ordy;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reads only; the model queue predicts occupancy, ready, valid and order.
    task automatic run_stream(input int n, input int hold, input logic [31:0] base);
        logic [31:0] sb[$];
        int          sent = 0;
        int          got  = 0;
        int          cyc  = 0;
        bit          can_push;
        while (got < n && cyc < 400) begin
            drive(sent < n, 4'd0, base + 32'(sent * 16), cyc >= hold);
            @(negedge clk);
            chk("stream occupancy", 64'(occupancy), 64'(sb.size()));
            chk("stream in_ready", 64'(in_ready), 64'(sb.size() < DEPTH));
            chk("stream out_valid", 64'(out_valid), 64'(sb.size() != 0));
            can_push = (sb.size() < DEPTH);
            if (sb.size() != 0 && out_ready) begin
                chk($sformatf("stream order %0d", got), 64'(hex_address), 64'(sb[0]));
                void'(sb.pop_front());
                got++;
            end
            if (in_valid && can_push) begin
                sb.push_back(in_addr);
                sent++;
            end
            next_cycle();
            cyc++;
        end
        drive(1'b0, 4'd0, 32'd0, 1'b0);
        chk("stream drained", 64'(got), 64'(n));
    endtask

    task automatic push_illegal(input int n);
        int acc = 0;
        int cyc = 0;
        while (acc < n && cyc < n + 50) begin
            drive(1'b1, (acc % 2 == 0) ? 4'hF : 4'hA, 32'(acc), 1'b1);
            @(negedge clk);
            if (in_ready) acc++;
            next_cycle();
            cyc++;
        end
        drive(1'b0, 4'd0, 32'd0, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("illegal pushes accepted", 64'(acc), 64'(n));
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 4'd0, 32'd0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_state("reset values");
        rst = 1'b0;
        next_cycle();

        //       iv op     addr    ordy ov ty ha       clr dmp idl occ iss drp
        vt[0]  = mk(1, 4'd0, 'h1040, 1, 0, 0, 0,       0, 0, 1, 0, 0, 0);
        vt[1]  = mk(0, 4'd0, 0,      1, 1, 0, 'h1040,  0, 0, 0, 1, 0, 0);
        vt[2]  = mk(0, 4'd0, 0,      1, 0, 0, 0,       0, 0, 1, 0, 1, 0);
        vt[3]  = mk(1, 4'd1, 'h100,  1, 0, 0, 0,       0, 0, 1, 0, 1, 0);
        vt[4]  = mk(1, 4'd8, 0,      1, 1, 1, 'h100,   0, 0, 0, 1, 1, 0);
        vt[5]  = mk(1, 4'd9, 0,      1, 0, 0, 0,       0, 0, 0, 1, 2, 0);
        vt[6]  = mk(1, 4'd0, 'h200,  1, 0, 0, 0,       1, 0, 0, 1, 2, 0);
        vt[7]  = mk(0, 4'd0, 0,      1, 1, 0, 'h200,   0, 1, 0, 1, 2, 0);
        vt[8]  = mk(0, 4'd0, 0,      1, 0, 0, 0,       0, 0, 1, 0, 3, 0);
        vt[9]  = mk(1, 4'd3, 0,      1, 0, 0, 0,       0, 0, 1, 0, 3, 0);
        vt[10] = mk(1, 4'd7, 0,      1, 0, 0, 0,       0, 0, 0, 1, 3, 0);
        vt[11] = mk(1, 4'd15, 0,     1, 0, 0, 0,       0, 0, 0, 1, 3, 1);
        vt[12] = mk(0, 4'd0, 0,      1, 0, 0, 0,       0, 0, 0, 1, 3, 2);
        vt[13] = mk(0, 4'd0, 0,      1, 0, 0, 0,       0, 0, 1, 0, 3, 3);
        vt[14] = mk(1, 4'd0, 'h300,  0, 0, 0, 0,       0, 0, 1, 0, 3, 3);
        vt[15] = mk(1, 4'd8, 0,      0, 1, 0, 'h300,   0, 0, 0, 1, 3, 3);
        vt[16] = mk(0, 4'd0, 0,      0, 1, 0, 'h300,   0, 0, 0, 2, 3, 3);
        vt[17] = mk(0, 4'd0, 0,      1, 1, 0, 'h300,   0, 0, 0, 2, 3, 3);
        vt[18] = mk(0, 4'd0, 0,      1, 0, 0, 0,       0, 0, 0, 1, 4, 3);
        vt[19] = mk(0, 4'd0, 0,      1, 0, 0, 0,       1, 0, 0, 0, 4, 3);
        vt[20] = mk(0, 4'd0, 0,      1, 0, 0, 0,       0, 0, 1, 0, 4, 3);

        for (int i = 0; i < 21; i++) begin
            drive(vt[i].iv, vt[i].op, vt[i].addr, vt[i].ordy);
            @(negedge clk);
            chk($sformatf("vec%0d valid/pulse/idle/occ", i),
                64'({out_valid, clear_stats, dump_stats, idle, occupancy}),
                64'({vt[i].ov, vt[i].clr, vt[i].dmp, vt[i].idl, vt[i].occ}));
            if (vt[i].ov) begin
                chk($sformatf("vec%0d head", i), 64'({access_type, hex_address}),
                    64'({vt[i].ty, vt[i].ha}));
            end
            chk($sformatf("vec%0d counters", i), 64'({issued_count, dropped_count}),
                64'({vt[i].iss, vt[i].drp}));
            next_cycle();
        end

        // Backpressure with a ninth record held by the source, then a wrapping stream.
        run_stream(9, 12, 32'h0000_1000);
        run_stream(20, 10, 32'h0000_8000);
        @(negedge clk);
        chk("issued after streams", 64'(issued_count), 64'd33);
        next_cycle();

        // Five entries queued with a clear pulse in flight, then reset.
        drive(1'b1, 4'd0, 32'hA0, 1'b0); next_cycle();
        drive(1'b1, 4'd8, 32'h0,  1'b0); next_cycle();
        drive(1'b1, 4'd0, 32'hA1, 1'b0); next_cycle();
        drive(1'b1, 4'd0, 32'hA2, 1'b0); next_cycle();
        drive(1'b1, 4'd0, 32'hA3, 1'b0); next_cycle();
        drive(1'b1, 4'd0, 32'hA4, 1'b1);
        @(negedge clk);
        chk("pre-reset head", 64'({out_valid, hex_address, occupancy}), 64'({1'b1, 32'hA0, 4'd5}));
        next_cycle();
        drive(1'b1, 4'd0, 32'hA5, 1'b0);
        @(negedge clk);
        chk("pre-reset ctrl head", 64'({out_valid, occupancy}), 64'({1'b0, 4'd5}));
        next_cycle();
        drive(1'b0, 4'd0, 32'h0, 1'b0);
        @(negedge clk);
        chk("pre-reset pulse", 64'({clear_stats, dump_stats, idle, occupancy}),
            64'({1'b1, 1'b0, 1'b0, 4'd5}));
        #1 rst = 1'b1;
        #1 chk_reset_state("async reset mid-cycle");
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_reset_state("after reset release");
        next_cycle();

        drive(1'b1, 4'd2, 32'hDEAD_BEC0, 1'b1);
        next_cycle();
        drive(1'b0, 4'd0, 32'h0, 1'b1);
        @(negedge clk);
        chk("post-reset invalidate", 64'({out_valid, access_type, hex_address}),
            64'({1'b1, 2'd2, 32'hDEAD_BEC0}));
        next_cycle();
        @(negedge clk);
        chk("post-reset issued/idle", 64'({issued_count, idle, occupancy}),
            64'({32'd1, 1'b1, 4'd0}));
        next_cycle();

        // Drive dropped_count to saturation and past it.
        push_illegal(65534);
        chk("dropped below saturation", 64'(dropped_count), 64'(16'hFFFE));
        push_illegal(1);
        chk("dropped at saturation", 64'(dropped_count), 64'(16'hFFFF));
        push_illegal(3);
        chk("dropped holds", 64'({dropped_count, issued_count, out_valid, idle}),
            64'({16'hFFFF, 32'd1, 1'b0, 1'b1}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
